// File: rtl/host_mem_arbiter_pkg.sv
// Shared FSM encoding and index helpers for the host memory arbiter.
package host_mem_arbiter_pkg;

  typedef logic [0:0] arb_state_e;
  localparam arb_state_e ARB  = 1'b0;
  localparam arb_state_e HOLD = 1'b1;

  // Width of a master index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_masters);
    return (num_masters > 2) ? $clog2(num_masters) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_masters);
    return (idx + 1 >= num_masters) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/host_mem_arbiter_id_fifo.sv
// FIFO of master IDs for granted transactions, used to steer in-order responses.
module host_mem_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_id_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign head_id_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/host_mem_arbiter.sv
// Round-robin arbiter sharing one OBI host memory port between several OBI masters.
module host_mem_arbiter
  import host_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [DATA_WIDTH/8-1:0]           s_be_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic                              s_gnt_i,
  input  logic                              s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i,
  output logic                              err_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned ID_W = id_width(NUM_MASTERS);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] hold_sel_q, hold_sel_d;
  logic [ID_W-1:0] arb_sel, rr_idx, cur_sel, head_id;
  logic            arb_found;
  logic            s_req;
  logic            grant;
  logic            rsp_pop;
  logic            fifo_full, fifo_empty;
  logic            err_q;
  logic [DATA_WIDTH-1:0] rdata;

  logic [BE_W-1:0]       be_arr    [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign be_arr[g]    = m_be_i[g*BE_W +: BE_W];
    assign addr_arr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester at or after the priority pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    rr_idx    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      rr_idx = ID_W'((32'(ptr_q) + i) % NUM_MASTERS);
      if (!arb_found && m_req_i[rr_idx]) begin
        arb_found = 1'b1;
        arb_sel   = rr_idx;
      end
    end
  end

  // Once a request is presented without a grant, the slave sees only that master.
  always_comb begin
    cur_sel = arb_sel;
    s_req   = 1'b0;
    if (state_q == HOLD) begin
      cur_sel = hold_sel_q;
      s_req   = m_req_i[hold_sel_q];
    end else begin
      s_req = arb_found && !fifo_full;
    end
    s_req = s_req && rst_ni;
  end

  assign grant     = s_req && s_gnt_i;
  assign s_req_o   = s_req;
  assign s_we_o    = s_req && m_we_i[cur_sel];
  assign s_be_o    = s_req ? be_arr[cur_sel]    : '0;
  assign s_addr_o  = s_req ? addr_arr[cur_sel]  : '0;
  assign s_wdata_o = s_req ? wdata_arr[cur_sel] : '0;

  always_comb begin
    m_gnt_o          = '0;
    m_gnt_o[cur_sel] = grant;
  end

  assign rsp_pop = s_rvalid_i && !fifo_empty;
  assign rdata   = rsp_pop ? s_rdata_i : {DATA_WIDTH{1'b0}};

  always_comb begin
    m_rvalid_o          = '0;
    m_rvalid_o[head_id] = rsp_pop;
  end

  assign m_rdata_o = {NUM_MASTERS{rdata}};
  assign err_o     = err_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_sel_d = hold_sel_q;
    if (grant) begin
      state_d = ARB;
      ptr_d   = ID_W'(rr_next(32'(cur_sel), NUM_MASTERS));
    end else if (state_q == HOLD) begin
      if (!s_req) begin
        state_d = ARB;
      end
    end else if (s_req) begin
      state_d    = HOLD;
      hold_sel_d = arb_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      hold_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_sel_q <= hold_sel_d;
      err_q      <= err_q | (s_rvalid_i && fifo_empty);
    end
  end

  host_mem_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (cur_sel),
    .pop_i     (rsp_pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_host_mem_arbiter.sv
// Randomised bench: a transaction-level arbiter/memory model feeds scoreboards checked by a monitor.
`timescale 1ns/1ps
module tb_host_mem_arbiter;

  localparam int NM = 3;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0]    m_req = '0;
  logic [NM-1:0]    m_we = '0;
  logic [NM*BW-1:0] m_be = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdata = '0;
  logic [NM-1:0]    m_gnt, m_rvalid;
  logic [NM*DW-1:0] m_rdata;
  logic             s_req, s_we, err;
  logic [BW-1:0]    s_be;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_gnt = 1'b0;
  logic             s_rvalid = 1'b0;
  logic [DW-1:0]    s_rdata = '0;

  always #5 clk = ~clk;

  host_mem_arbiter #(
    .NUM_MASTERS(NM), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .err_o(err)
  );

  typedef struct { int cyc; int mst; logic [DW-1:0] data; } exp_t;
  typedef struct { int mst; int ready; } pend_t;

  exp_t  gnt_q[$];
  exp_t  rsp_q[$];
  pend_t mem_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr_m = 0;
  int out_m = 0;
  int commit_sel = 0;
  bit commit_v = 1'b0;
  bit chk_en = 1'b0;
  bit exp_sreq = 1'b0;
  logic [1+BW+AW+DW-1:0] exp_bus = '0;
  logic [NM-1:0] gnt_prev = '0;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic resetModel();
    ptr_m = 0;
    out_m = 0;
    commit_v = 1'b0;
    gnt_prev = '0;
    exp_sreq = 1'b0;
    gnt_q.delete();
    rsp_q.delete();
    mem_q.delete();
  endtask

  // One clock of stimulus; the model decides what the arbiter must do with it.
  task automatic applyStimulus(input int req_pct, input int gnt_pct, input int rsp_pct,
                               input logic [NM-1:0] mask);
    int sel;
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < NM; m++) begin
      if (gnt_prev[m]) m_req[m] = 1'b0;
      if (!m_req[m] && mask[m] && ($urandom_range(99) < req_pct)) begin
        m_req[m] = 1'b1;
        m_we[m] = 1'($urandom);
        m_be[m*BW +: BW] = BW'($urandom);
        m_addr[m*AW +: AW] = $urandom;
        m_wdata[m*DW +: DW] = $urandom;
      end
    end
    s_gnt = ($urandom_range(99) < gnt_pct);
    s_rvalid = 1'b0;
    s_rdata = '0;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && ($urandom_range(99) < rsp_pct)) begin
      s_rvalid = 1'b1;
      s_rdata = $urandom;
      rsp_q.push_back('{cyc, mem_q[0].mst, s_rdata});
      mem_q.delete(0);
    end
    sel = -1;
    if (commit_v) begin
      if (m_req[commit_sel]) sel = commit_sel;
    end else if (out_m < MO) begin
      for (int i = 0; i < NM; i++) begin
        if (sel < 0 && m_req[(ptr_m + i) % NM]) sel = (ptr_m + i) % NM;
      end
    end
    exp_sreq = (sel >= 0);
    exp_bus = '0;
    if (exp_sreq)
      exp_bus = {m_we[sel], m_be[sel*BW +: BW], m_addr[sel*AW +: AW], m_wdata[sel*DW +: DW]};
    gnt_prev = '0;
    commit_v = 1'b0;
    if (exp_sreq && s_gnt) begin
      gnt_q.push_back('{cyc, sel, DW'(0)});
      mem_q.push_back('{sel, cyc + 1 + int'($urandom_range(3))});
      out_m++;
      ptr_m = (sel + 1) % NM;
      gnt_prev[sel] = 1'b1;
    end else if (exp_sreq) begin
      commit_v = 1'b1;
      commit_sel = sel;
    end
    if (s_rvalid) out_m--;
  endtask

  // Monitor: compares DUT outputs against whatever the stimulus side queued.
  initial begin
    logic [NM-1:0] eg, er;
    logic [DW-1:0] ed;
    int em;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checkOutput("s_req", s_req, exp_sreq);
        if (exp_sreq) checkOutput("s_bus", {s_we, s_be, s_addr, s_wdata}, exp_bus);
        eg = '0;
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
          eg[gnt_q[0].mst] = 1'b1;
          gnt_q.delete(0);
        end
        checkOutput("m_gnt", m_gnt, eg);
        er = '0;
        em = 0;
        ed = '0;
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          em = rsp_q[0].mst;
          er[em] = 1'b1;
          ed = rsp_q[0].data;
          rsp_q.delete(0);
        end
        checkOutput("m_rvalid", m_rvalid, er);
        if (er != '0) checkOutput("m_rdata", m_rdata[em*DW +: DW], ed);
      end
    end
  end

  task automatic releaseReset();
    m_req = '0;
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    m_addr = {$urandom, $urandom, $urandom};
    m_wdata = {$urandom, $urandom, $urandom};
    m_be = '1;
    #12;
    m_req = '1;
    s_gnt = 1'b1;
    #2;
    checkOutput("rst_s_req", s_req, 0);
    checkOutput("rst_s_addr", s_addr, 0);
    checkOutput("rst_m_gnt", m_gnt, 0);
    checkOutput("rst_m_rvalid", m_rvalid, 0);
    checkOutput("rst_err", err, 0);
    releaseReset();

    @(posedge clk);
    #1;
    s_rvalid = 1'b1;
    s_rdata = 32'hdeadbeef;
    @(negedge clk);
    checkOutput("spurious_rvalid", m_rvalid, 0);
    @(posedge clk);
    #1;
    s_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("err_sticky", err, 1);
    end
    rst_n = 1'b0;
    releaseReset();
    #1;
    checkOutput("err_cleared", err, 0);

    chk_en = 1'b1;
    repeat (60)  applyStimulus(100, 100, 100, 3'b001);
    repeat (400) applyStimulus(100, 100, 90, '1);
    repeat (600) applyStimulus(60, 30, 50, '1);
    repeat (400) applyStimulus(80, 80, 5, '1);

    guard = 0;
    while (out_m < 2 && guard < 200) begin
      applyStimulus(100, 100, 0, '1);
      guard++;
    end
    checks++;
    if (out_m < 2) begin
      failures++;
      $display("[TB] FAIL outstanding_fill cyc=%0d got=%0d exp>=2", cyc, out_m);
    end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_s_req", s_req, 0);
    checkOutput("midrst_m_gnt", m_gnt, 0);
    checkOutput("midrst_m_rvalid", m_rvalid, 0);
    checkOutput("midrst_err", err, 0);
    releaseReset();
    chk_en = 1'b1;

    repeat (300) applyStimulus(100, 70, 60, '1);
    repeat (40)  applyStimulus(0, 100, 100, '1);
    @(negedge clk);
    #1;
    checkOutput("final_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
